// File: rtl/gups_pkg.sv
// Shared types and constants for the GUPS random-access datapath.
package gups_pkg;

  localparam int GUPS_AW    = 64;
  localparam int GUPS_DW    = 64;
  localparam int GUPS_CNT_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } gups_upd_state_t;

endpackage

// File: rtl/gups_update_engine_if.sv
// Request, memory and status bundle of the GUPS update engine; master = engine side.
// GUPS_UPD_STATS_EN adds the read/write stall counters.
interface gups_update_engine_if
  import gups_pkg::*;
#(
  parameter int AW = GUPS_AW,
  parameter int DW = GUPS_DW
) ();

  logic                  enable;
  logic                  req_valid;
  logic [AW-1:0]         req_addr;
  logic                  req_ready;
  logic                  mem_rd_valid;
  logic [AW-1:0]         mem_rd_addr;
  logic                  mem_rd_ready;
  logic                  mem_rsp_valid;
  logic [DW-1:0]         mem_rsp_data;
  logic                  mem_rsp_ready;
  logic                  mem_wr_valid;
  logic [AW-1:0]         mem_wr_addr;
  logic [DW-1:0]         mem_wr_data;
  logic                  mem_wr_ready;
  logic                  busy;
  logic                  done;
  logic                  err;
  logic [GUPS_CNT_W-1:0] update_count;
`ifdef GUPS_UPD_STATS_EN
  logic [GUPS_CNT_W-1:0] rd_stall_count;
  logic [GUPS_CNT_W-1:0] wr_stall_count;
`endif

  modport master (
    input  enable, req_valid, req_addr, mem_rd_ready,
           mem_rsp_valid, mem_rsp_data, mem_wr_ready,
    output req_ready, mem_rd_valid, mem_rd_addr, mem_rsp_ready,
           mem_wr_valid, mem_wr_addr, mem_wr_data,
           busy, done, err, update_count
`ifdef GUPS_UPD_STATS_EN
    , output rd_stall_count, wr_stall_count
`endif
  );

  modport slave (
    output enable, req_valid, req_addr, mem_rd_ready,
           mem_rsp_valid, mem_rsp_data, mem_wr_ready,
    input  req_ready, mem_rd_valid, mem_rd_addr, mem_rsp_ready,
           mem_wr_valid, mem_wr_addr, mem_wr_data,
           busy, done, err, update_count
`ifdef GUPS_UPD_STATS_EN
    , input rd_stall_count, wr_stall_count
`endif
  );

endinterface

// File: rtl/gups_addr_fifo.sv
// Synchronous FIFO tracking outstanding request addresses; head is visible combinationally.
// Push is ignored when full and pop when empty; simultaneous push/pop keeps occupancy.
module gups_addr_fifo #(
  parameter  int DEPTH = 8,
  parameter  int W     = 64,
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty,
  output logic [PW:0]  count
);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   cnt;
  logic          do_push;
  logic          do_pop;

  assign full    = (cnt == (PW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign head    = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointers are exactly log2(DEPTH) wide so they wrap without compare logic.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + (PW+1)'(1);
        2'b01:   cnt <= cnt - (PW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/gups_update_engine.sv
// GUPS read-modify-write: read each address, XOR the returned word with it, write it back.
// Read and write issue one cycle after their handshakes; registers hold until ready. GUPS_UPD_STATS_EN adds stall counters.
module gups_update_engine
  import gups_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = GUPS_AW,
  parameter int DW    = GUPS_DW
) (
  input logic                 clk,
  input logic                 rst,
  gups_update_engine_if.master bus
);

  localparam int PW = $clog2(DEPTH);

  gups_upd_state_t       state_q;
  gups_upd_state_t       state_d;
  logic                  req_ready;
  logic                  rsp_ready;
  logic                  req_fire;
  logic                  rsp_fire;
  logic                  rd_vld_q;
  logic [AW-1:0]         rd_addr_q;
  logic                  wr_vld_q;
  logic [AW-1:0]         wr_addr_q;
  logic [DW-1:0]         wr_data_q;
  logic                  err_q;
  logic                  done_q;
  logic [GUPS_CNT_W-1:0] cnt_q;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [AW-1:0]         fifo_head;
  logic [PW:0]           fifo_count;

  gups_addr_fifo #(.DEPTH(DEPTH), .W(AW)) u_addr_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (req_fire),
    .push_data (bus.req_addr),
    .pop       (rsp_fire),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Once draining, enable is ignored until every read and write has retired.
  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    rsp_ready = !fifo_empty && (!wr_vld_q || bus.mem_wr_ready);
    case (state_q)
      IDLE: begin
        if (bus.enable) state_d = RUN;
      end
      RUN: begin
        req_ready = !fifo_full && (!rd_vld_q || bus.mem_rd_ready);
        if (!bus.enable) state_d = DRAIN;
      end
      DRAIN: begin
        if (fifo_count == '0 && !rd_vld_q && !wr_vld_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign req_fire = bus.req_valid && req_ready;
  assign rsp_fire = bus.mem_rsp_valid && rsp_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_vld_q  <= 1'b0;
      rd_addr_q <= '0;
      wr_vld_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      done_q <= (state_q == DRAIN) && (state_d == IDLE);

      if (req_fire) begin
        rd_vld_q  <= 1'b1;
        rd_addr_q <= bus.req_addr;
      end else if (bus.mem_rd_ready) begin
        rd_vld_q  <= 1'b0;
      end

      // Responses come back in order, so the FIFO head is the address this data belongs to.
      if (rsp_fire) begin
        wr_vld_q  <= 1'b1;
        wr_addr_q <= fifo_head;
        wr_data_q <= bus.mem_rsp_data ^ DW'(fifo_head);
      end else if (bus.mem_wr_ready) begin
        wr_vld_q  <= 1'b0;
      end

      if (bus.mem_rsp_valid && fifo_empty) err_q <= 1'b1;
      if (wr_vld_q && bus.mem_wr_ready)    cnt_q <= cnt_q + GUPS_CNT_W'(1);
    end
  end

`ifdef GUPS_UPD_STATS_EN
  logic [GUPS_CNT_W-1:0] rd_stall_q;
  logic [GUPS_CNT_W-1:0] wr_stall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_stall_q <= '0;
      wr_stall_q <= '0;
    end else if (state_q != IDLE) begin
      if (rd_vld_q && !bus.mem_rd_ready) rd_stall_q <= rd_stall_q + GUPS_CNT_W'(1);
      if (wr_vld_q && !bus.mem_wr_ready) wr_stall_q <= wr_stall_q + GUPS_CNT_W'(1);
    end
  end

  assign bus.rd_stall_count = rd_stall_q;
  assign bus.wr_stall_count = wr_stall_q;
`endif

  assign bus.req_ready     = req_ready;
  assign bus.mem_rd_valid  = rd_vld_q;
  assign bus.mem_rd_addr   = rd_addr_q;
  assign bus.mem_rsp_ready = rsp_ready;
  assign bus.mem_wr_valid  = wr_vld_q;
  assign bus.mem_wr_addr   = wr_addr_q;
  assign bus.mem_wr_data   = wr_data_q;
  assign bus.busy          = (state_q != IDLE);
  assign bus.done          = done_q;
  assign bus.err           = err_q;
  assign bus.update_count  = cnt_q;

endmodule

// File: tb/tb_gups_update_engine.sv
// Bench for gups_update_engine: behavioural memory with fixed read latency, scoreboard of
// expected writes filled on request handshakes and drained on write handshakes.
module tb_gups_update_engine;

  typedef struct {
    logic [63:0] addr;
    logic [63:0] data;
  } exp_t;

  typedef struct {
    logic [63:0] addr;
    int          due;
  } pend_t;

  logic clk;
  logic rst;
  int   cyc;
  int   n_checks;
  int   n_errors;
  int   n_acc;
  int   req_waits;
  int   rd_lat;
  int   rsp_limit;
  int   n_rsp;
  int   spur_cnt;
  bit   rd_rand;
  exp_t  sb[$];
  pend_t pend[$];
  exp_t  mon_e;
  logic [63:0] last_wr_data;

  gups_update_engine_if #(.AW(64), .DW(64)) bus ();

  gups_update_engine #(.DEPTH(8), .AW(64), .DW(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] rdata(input logic [63:0] a);
    if (a == 64'h10) return 64'hFF;
    return (a * 64'h9E37_79B9_7F4A_7C15) ^ 64'h0123_4567_89AB_CDEF;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Memory side: read acceptance and in-order responses, driven on the falling edge.
  initial begin : mem_driver
    int spur_seen;
    spur_seen = 0;
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_data  = '0;
    bus.mem_rd_ready  = 1'b1;
    forever begin
      @(negedge clk);
      bus.mem_rd_ready = rd_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      if (rst) begin
        bus.mem_rsp_valid = 1'b0;
      end else if (spur_cnt != spur_seen) begin
        spur_seen         = spur_cnt;
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_data  = 64'hDEAD_BEEF_0000_0001;
      end else if (pend.size() > 0 && pend[0].due <= cyc && (rsp_limit < 0 || n_rsp < rsp_limit)) begin
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_data  = rdata(pend[0].addr);
      end else begin
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_data  = '0;
      end
    end
  end

  // Handshake monitor, sampled after all falling-edge drives have settled.
  initial begin : monitor
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        pend.delete();
        sb.delete();
      end else begin
        if (bus.req_valid && bus.req_ready)
          sb.push_back('{addr: bus.req_addr, data: rdata(bus.req_addr) ^ bus.req_addr});
        if (bus.mem_rd_valid && bus.mem_rd_ready)
          pend.push_back('{addr: bus.mem_rd_addr, due: cyc + rd_lat});
        if (bus.mem_rsp_valid && bus.mem_rsp_ready) begin
          if (pend.size() > 0) void'(pend.pop_front());
          n_rsp++;
        end
        if (bus.mem_wr_valid && bus.mem_wr_ready) begin
          chk("wr_expected", 64'(sb.size() > 0), 64'd1);
          if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            chk("wr_addr", bus.mem_wr_addr, mon_e.addr);
            chk("wr_data", bus.mem_wr_data, mon_e.data);
          end
          last_wr_data = bus.mem_wr_data;
        end
      end
    end
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", n_errors);
    $fatal(1, "watchdog");
  end

  // Call on a falling edge; returns on a falling edge.
  task automatic send(input logic [63:0] a, input int budget, output bit ok);
    ok = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_addr  = a;
    for (int i = 0; i < budget; i++) begin
      #2;
      if (bus.req_ready) begin
        ok = 1'b1;
        break;
      end
      req_waits++;
      @(negedge clk);
    end
    if (ok) begin
      n_acc++;
      @(negedge clk);
      chk("rd_vld_next", 64'(bus.mem_rd_valid), 64'd1);
      chk("rd_addr_next", bus.mem_rd_addr, a);
    end
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_sb(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !bus.mem_wr_valid) break;
    end
    @(negedge clk);
    chk({tag, "_sb_empty"}, 64'(sb.size()), 64'd0);
    chk({tag, "_count"}, 64'(bus.update_count), 64'(n_acc));
  endtask

  task automatic wait_done(input string tag, input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.done) begin
        seen = 1'b1;
        chk({tag, "_busy_at_done"}, 64'(bus.busy), 64'd0);
        chk({tag, "_sb_at_done"}, 64'(sb.size()), 64'd0);
        break;
      end
    end
    chk({tag, "_done_seen"}, 64'(seen), 64'd1);
    @(negedge clk);
    chk({tag, "_done_pulse"}, 64'(bus.done), 64'd0);
  endtask

  task automatic chk_reset(input string p);
    chk({p, "_req_ready"}, 64'(bus.req_ready), 64'd0);
    chk({p, "_rd_vld"}, 64'(bus.mem_rd_valid), 64'd0);
    chk({p, "_rd_addr"}, bus.mem_rd_addr, 64'd0);
    chk({p, "_rsp_ready"}, 64'(bus.mem_rsp_ready), 64'd0);
    chk({p, "_wr_vld"}, 64'(bus.mem_wr_valid), 64'd0);
    chk({p, "_wr_addr"}, bus.mem_wr_addr, 64'd0);
    chk({p, "_wr_data"}, bus.mem_wr_data, 64'd0);
    chk({p, "_busy"}, 64'(bus.busy), 64'd0);
    chk({p, "_done"}, 64'(bus.done), 64'd0);
    chk({p, "_err"}, 64'(bus.err), 64'd0);
    chk({p, "_count"}, 64'(bus.update_count), 64'd0);
  endtask

  task automatic start_run();
    @(negedge clk);
    bus.enable = 1'b1;
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin : main
    bit ok;
    cyc = 0; n_checks = 0; n_errors = 0; n_acc = 0; req_waits = 0;
    rd_lat = 3; rsp_limit = -1; n_rsp = 0; spur_cnt = 0; rd_rand = 1'b0;
    last_wr_data = '0;
    rst = 1'b1;
    bus.enable = 1'b0; bus.req_valid = 1'b0; bus.req_addr = '0; bus.mem_wr_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset("por");
    rst = 1'b0;

    // Single update: 0xFF ^ 0x10 = 0xEF
    start_run();
    send(64'h10, 20, ok);
    chk("single_acc", 64'(ok), 64'd1);
    wait_sb("single", 100);
    chk("single_wdata", last_wr_data, 64'hEF);
    chk("single_count1", 64'(bus.update_count), 64'd1);
    bus.enable = 1'b0;
    wait_done("single", 50);

    // Back-to-back, memory always ready: no request may wait
    start_run();
    req_waits = 0;
    for (int i = 0; i < 16; i++) begin
      send(64'h2000 + 64'(i) * 64'h38, 10, ok);
      chk("b2b_acc", 64'(ok), 64'd1);
    end
    chk("b2b_waits", 64'(req_waits), 64'd0);
    wait_sb("b2b", 200);

    // Random read backpressure, order and read-register hold via scoreboard
    rd_rand = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send(64'h5_0000 + 64'($urandom_range(0, 4095)) * 64'h8, 60, ok);
      chk("rdbp_acc", 64'(ok), 64'd1);
    end
    rd_rand = 1'b0;
    wait_sb("rdbp", 300);

    // FIFO full with responses withheld
    rsp_limit = n_rsp;
    for (int i = 0; i < 8; i++) begin
      send(64'h9000 + 64'(i) * 64'h8, 10, ok);
      chk("full_acc", 64'(ok), 64'd1);
    end
    send(64'h9100, 6, ok);
    chk("full_block", 64'(ok), 64'd0);
    chk("full_req_ready", 64'(bus.req_ready), 64'd0);
    rsp_limit = n_rsp + 1;
    send(64'h9108, 20, ok);
    chk("full_one_more", 64'(ok), 64'd1);
    send(64'h9110, 6, ok);
    chk("full_block_again", 64'(ok), 64'd0);
    rsp_limit = -1;
    wait_sb("full", 200);

    // Write backpressure for 5 cycles
    @(negedge clk);
    bus.mem_wr_ready = 1'b0;
    send(64'hA000, 10, ok);
    send(64'hA040, 10, ok);
    for (int i = 0; i < 30; i++) begin
      if (bus.mem_wr_valid) break;
      @(negedge clk);
    end
    chk("wbp_wr_vld", 64'(bus.mem_wr_valid), 64'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("wbp_rsp_ready", 64'(bus.mem_rsp_ready), 64'd0);
      chk("wbp_wr_hold", 64'(bus.mem_wr_valid), 64'd1);
      chk("wbp_wr_addr", bus.mem_wr_addr, 64'hA000);
      chk("wbp_wr_data", bus.mem_wr_data, rdata(64'hA000) ^ 64'hA000);
      chk("wbp_count", 64'(bus.update_count), 64'(n_acc - 2));
    end
    bus.mem_wr_ready = 1'b1;
    wait_sb("wbp", 100);

    // Spurious response with FIFO empty
    spur_cnt++;
    repeat (3) @(negedge clk);
    chk("spur_err", 64'(bus.err), 64'd1);
    chk("spur_no_wr", 64'(bus.mem_wr_valid), 64'd0);
    chk("spur_count", 64'(bus.update_count), 64'(n_acc));
    bus.enable = 1'b0;
    wait_done("spur", 50);

    // Drain with 3 outstanding
    start_run();
    rsp_limit = n_rsp;
    for (int i = 0; i < 3; i++) send(64'hC000 + 64'(i) * 64'h10, 10, ok);
    bus.enable = 1'b0;
    repeat (2) @(negedge clk);
    chk("drain_busy", 64'(bus.busy), 64'd1);
    rsp_limit = -1;
    wait_done("drain", 100);
    chk("drain_count", 64'(bus.update_count), 64'(n_acc));
    chk("drain_err_sticky", 64'(bus.err), 64'd1);

    // Reset mid-flight with reads outstanding and a write pending
    start_run();
    rsp_limit = n_rsp + 1;
    bus.mem_wr_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(64'hE000 + 64'(i) * 64'h10, 10, ok);
    repeat (6) @(negedge clk);
    chk("midrst_wr_pending", 64'(bus.mem_wr_valid), 64'd1);
    rst = 1'b1;
    bus.enable = 1'b0;
    @(negedge clk);
    chk_reset("midrst");
    n_acc = 0;
    bus.mem_wr_ready = 1'b1;
    rsp_limit = -1;
    @(negedge clk);
    rst = 1'b0;

    // Engine is usable again after the mid-flight reset
    start_run();
    send(64'h10, 20, ok);
    wait_sb("post", 100);
    chk("post_err", 64'(bus.err), 64'd0);
    bus.enable = 1'b0;
    wait_done("post", 50);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/gups_update_engine.md
# gups_update_engine

Read-modify-write stage directly downstream of the GUPS address generator. Accepts masked table addresses, issues a memory read per address, XORs the returned word with that address, and writes the result back to the same location. Tracks outstanding reads in an in-order address FIFO and reports update count, drain completion and protocol errors.

## Interface

- `DEPTH`, 8, maximum outstanding reads; power of two, 2..64
- `AW`, 64, address width
- `DW`, 64, data width
- `clk` in 1: single clock, 200 MHz
- `rst` in 1: synchronous, active-high reset
- `enable` in 1: run request; low starts drain
- `req_valid` in 1: address valid from generator
- `req_addr` in AW: masked table address
- `req_ready` out 1: address accepted when high with `req_valid`
- `mem_rd_valid` out 1, `mem_rd_addr` out AW, `mem_rd_ready` in 1: read request channel
- `mem_rsp_valid` in 1, `mem_rsp_data` in DW, `mem_rsp_ready` out 1: read response channel, in order
- `mem_wr_valid` out 1, `mem_wr_addr` out AW, `mem_wr_data` out DW, `mem_wr_ready` in 1: write channel
- `busy` out 1: state is not IDLE
- `done` out 1: one-cycle pulse on DRAIN→IDLE
- `err` out 1: sticky protocol error
- `update_count` out 32: completed writes, wraps at 2^32

## Operation

- FSM states: IDLE, RUN, DRAIN. Reset → IDLE.
- IDLE→RUN when `enable`=1. RUN→DRAIN when `enable`=0. DRAIN→IDLE when FIFO empty, `mem_rd_valid`=0 and `mem_wr_valid`=0. DRAIN→RUN is not allowed; `enable` is ignored until IDLE.
- `req_ready` = RUN && FIFO not full && (!`mem_rd_valid` || `mem_rd_ready`). Combinational, no dependency on `req_valid`.
- Request handshake: `req_addr` loads the read register and is pushed into the FIFO in the same cycle.
- Read register holds `mem_rd_valid`/`mem_rd_addr` stable until `mem_rd_ready`.
- `mem_rsp_ready` = FIFO not empty && (!`mem_wr_valid` || `mem_wr_ready`).
- Response handshake: pop FIFO head H. Load the write register with addr=H and data=`mem_rsp_data` ^ zero-extended H.
- The write register holds until `mem_wr_ready`. `update_count` increments on every write handshake.
- `mem_rsp_valid` while FIFO is empty sets `err` and drops the response. `err` clears only on `rst`.
- FIFO push and pop in the same cycle leave occupancy unchanged. Full: no push, because `req_ready`=0. Empty: no pop.
- Pointers are log2(DEPTH) bits and wrap naturally. Occupancy is log2(DEPTH)+1 bits.

## Timing

- Reset values: `req_ready`=0, `mem_rd_valid`=0, `mem_rsp_ready`=0, `mem_wr_valid`=0, `busy`=0, `done`=0, `err`=0, `update_count`=0. Address/data outputs reset to 0.
- Request accepted in cycle N → `mem_rd_valid` high in N+1.
- Response accepted in cycle M → `mem_wr_valid` high in M+1.
- Sustained throughput: one update per cycle when memory is always ready. The generator's 1-in-4 rate never fills the FIFO unless read latency exceeds 4×DEPTH cycles.
- `done` is asserted in the first IDLE cycle after DRAIN. `busy` falls in that same cycle.
- `rst` mid-operation clears the FIFO, registers and counters in the next cycle. Pre-reset read responses must not arrive after reset; if one does, it sets `err`.

## Configuration

- `GUPS_UPD_STATS_EN` defined: adds outputs `rd_stall_count` (32) and `wr_stall_count` (32).
  - `rd_stall_count` counts cycles with `mem_rd_valid` && !`mem_rd_ready`.
  - `wr_stall_count` counts cycles with `mem_wr_valid` && !`mem_wr_ready`.
  - Both reset to 0, wrap, and are frozen in IDLE.
- Not defined: ports and counters are absent. All other behaviour is identical.

## Structure

- Shared package `gups_pkg`:
  - state enum `gups_upd_state_t` (IDLE, RUN, DRAIN)
  - `GUPS_AW`, `GUPS_DW` constants
  - `GUPS_CNT_W`=32
- Sub-module `gups_addr_fifo`: synchronous FIFO with push/pop/full/empty/occupancy, parameterised by DEPTH and width. Reused elsewhere for outstanding-request tracking.

## Test plan

- Single update: reset, `enable`=1, `req_addr`=0x10, memory returns 0xFF. → Write addr 0x10, data 0xEF, `update_count`=1. Then `enable`=0 → `done` pulse.
- Back-to-back: 16 requests with memory always ready and 3-cycle read latency. → 16 writes in request order, each data = rsp ^ addr, no stalls.
- FIFO full: DEPTH=8, responses withheld. → `req_ready` drops after 8 accepts. Release one response → exactly one more accept.
- Write backpressure: `mem_wr_ready`=0 for 5 cycles. → `mem_rsp_ready`=0 while write pending, write fields stable, no lost update.
- Spurious response with FIFO empty. → `err`=1, no write issued. `err` stays 1 until `rst`.
- Drain and reset: `enable`=0 with 3 outstanding → all 3 complete, then IDLE and `done`. Repeat with `rst` mid-flight → all outputs at reset values next cycle.
